// File: rtl/arm_pkg.sv
// Shared definitions for the fetch stage: default widths, FSM state type,
// the flush/NOP word and instruction size in bytes.
package arm_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 64;
  localparam int DEFAULT_INSTR_WIDTH = 32;
  localparam int INSTR_BYTES         = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory bus: fetch drives the byte address, memory returns
// the word combinationally.
interface instruction_fetch_if
  import arm_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) ();

  logic [ADDR_WIDTH-1:0]  imem_address;
  logic [INSTR_WIDTH-1:0] imem_data;

  modport master (output imem_address, input imem_data);
  modport slave  (input imem_address, output imem_data);

endinterface

// File: rtl/ifid_register.sv
// IF/ID pipeline register. flush inserts a bubble with a NOP word, kill only
// drops valid (used when the stage faults), load captures a fetched word.
module ifid_register
  import arm_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   flush,
  input  logic                   kill,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [ADDR_WIDTH-1:0]  ifid_pc,
  output logic [INSTR_WIDTH-1:0] ifid_instruction,
  output logic                   ifid_valid
);

  // Capture, flush, invalidate or hold; with no control asserted the register holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_pc          <= '0;
      ifid_instruction <= INSTR_WIDTH'(NOP_INSTR);
      ifid_valid       <= 1'b0;
    end else if (flush) begin
      ifid_instruction <= INSTR_WIDTH'(NOP_INSTR);
      ifid_valid       <= 1'b0;
    end else if (kill) begin
      ifid_valid       <= 1'b0;
    end else if (load) begin
      ifid_pc          <= pc_in;
      ifid_instruction <= instr_in;
      ifid_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory and fills IF/ID.
//
//   state | meaning
//   RUN   | fetching; branch redirect beats stall, stall beats sequential fetch
//   FAULT | bad PC or branch target seen; everything frozen until rst
module instruction_fetch
  import arm_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int                    INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int                    IMEM_SIZE   = 256,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  instruction_fetch_if.master    imem,
  output logic [ADDR_WIDTH-1:0]  ifid_pc,
  output logic [INSTR_WIDTH-1:0] ifid_instruction,
  output logic                   ifid_valid,
  output logic                   fault,
  output logic [ADDR_WIDTH-1:0]  fault_pc,
  output logic [31:0]            fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PC    = ADDR_WIDTH'(IMEM_SIZE - INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_bad;
  logic                  target_bad;
  logic                  ifid_load;
  logic                  ifid_flush;
  logic                  ifid_kill;

  // Full-width compare so high address bits can never alias into range.
  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    return ((a & ALIGN_MASK) != '0) || (a > LAST_PC);
  endfunction

  assign imem.imem_address = pc;

  // Decode this edge's action from state, priority and address checks.
  always_comb begin
    pc_bad     = addr_bad(pc);
    target_bad = addr_bad(branch_target);
    ifid_flush = 1'b0;
    ifid_kill  = 1'b0;
    ifid_load  = 1'b0;
    if (state == RUN) begin
      if (branch_taken) begin
        ifid_flush = !target_bad;
        ifid_kill  = target_bad;
      end else if (!stall) begin
        ifid_kill  = pc_bad;
        ifid_load  = !pc_bad;
      end
    end
  end

  // PC, fault capture, delivered-instruction counter and RUN/FAULT state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      fault       <= 1'b0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            if (target_bad) begin
              state    <= FAULT;
              fault    <= 1'b1;
              fault_pc <= branch_target;
            end else begin
              pc <= branch_target;
            end
          end else if (!stall) begin
            if (pc_bad) begin
              state    <= FAULT;
              fault    <= 1'b1;
              fault_pc <= pc;
            end else begin
              pc          <= pc + PC_STEP;
              fetch_count <= fetch_count + 32'd1;
            end
          end
        end
        FAULT: ;
        default: state <= FAULT;
      endcase
    end
  end

  ifid_register #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_ifid (
    .clk             (clk),
    .rst             (rst),
    .load            (ifid_load),
    .flush           (ifid_flush),
    .kill            (ifid_kill),
    .pc_in           (pc),
    .instr_in        (imem.imem_data),
    .ifid_pc         (ifid_pc),
    .ifid_instruction(ifid_instruction),
    .ifid_valid      (ifid_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized phase,
// every step compared against a rule-level reference model.
module tb_instruction_fetch;
  import arm_pkg::*;

  localparam int AW  = 64;
  localparam int IW  = 32;
  localparam int MSZ = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, stall = 1'b0, branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          stall16 = 1'b0, branch16 = 1'b0;
  logic [AW-1:0] target16 = '0;

  logic [AW-1:0] ifid_pc, fault_pc, ipc16, fpc16;
  logic [IW-1:0] ifid_instruction, instr16;
  logic          ifid_valid, fault, valid16, fault16;
  logic [31:0]   fetch_count, cnt16;

  instruction_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) imem_bus ();
  instruction_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) imem16_bus ();

  instruction_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .IMEM_SIZE(MSZ), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(imem_bus.master), .ifid_pc(ifid_pc),
    .ifid_instruction(ifid_instruction), .ifid_valid(ifid_valid), .fault(fault),
    .fault_pc(fault_pc), .fetch_count(fetch_count));

  instruction_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .IMEM_SIZE(16), .RESET_PC('0)) dut16 (
    .clk(clk), .rst(rst), .stall(stall16), .branch_taken(branch16),
    .branch_target(target16), .imem(imem16_bus.master), .ifid_pc(ipc16),
    .ifid_instruction(instr16), .ifid_valid(valid16), .fault(fault16),
    .fault_pc(fpc16), .fetch_count(cnt16));

  logic [7:0]  mem [MSZ];
  logic [31:0] prog [4];

  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    int b;
    b = int'(a[7:0]);
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  // Combinational little-endian memories of 256 and 16 bytes.
  always_comb begin
    imem_bus.imem_data = 32'h0;
    if (imem_bus.imem_address <= 64'(MSZ - 4) && imem_bus.imem_address[1:0] == 2'b00)
      imem_bus.imem_data = word_at(imem_bus.imem_address);
  end

  always_comb begin
    imem16_bus.imem_data = 32'h0;
    if (imem16_bus.imem_address <= 64'd12 && imem16_bus.imem_address[1:0] == 2'b00)
      imem16_bus.imem_data = word_at(imem16_bus.imem_address);
  end

  // Reference model state: what the stage should show after each edge.
  logic [AW-1:0] m_pc, m_ipc, m_fpc;
  logic [IW-1:0] m_instr;
  logic          m_valid, m_fault;
  logic [31:0]   m_cnt;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic is_bad(input logic [AW-1:0] a);
    return (a % 4 != 0) || (a > 64'(MSZ - 4));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the rules for one edge to the model, clock the DUT, compare everything.
  task automatic step();
    if (rst) begin
      m_pc = '0; m_ipc = '0; m_instr = '0; m_valid = 0;
      m_fault = 0; m_fpc = '0; m_cnt = '0;
    end else if (!m_fault) begin
      if (branch_taken) begin
        if (is_bad(branch_target)) begin
          m_fault = 1; m_fpc = branch_target; m_valid = 0;
        end else begin
          m_pc = branch_target; m_valid = 0; m_instr = '0;
        end
      end else if (!stall) begin
        if (is_bad(m_pc)) begin
          m_fault = 1; m_fpc = m_pc; m_valid = 0;
        end else begin
          m_ipc = m_pc; m_instr = word_at(m_pc); m_valid = 1;
          m_pc = m_pc + 64'd4; m_cnt = m_cnt + 32'd1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("imem_address", imem_bus.imem_address, m_pc);
    check("ifid_pc", ifid_pc, m_ipc);
    check("ifid_instruction", 64'(ifid_instruction), 64'(m_instr));
    check("ifid_valid", 64'(ifid_valid), 64'(m_valid));
    check("fault", 64'(fault), 64'(m_fault));
    check("fault_pc", fault_pc, m_fpc);
    check("fetch_count", 64'(fetch_count), 64'(m_cnt));
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) mem[i] = 8'($urandom);
    prog[0] = 32'h8b1f03e5; prog[1] = 32'hf84000a4;
    prog[2] = 32'h8b040086; prog[3] = 32'hf80010a6;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) mem[k*4+j] = prog[k][j*8 +: 8];

    // Reset state
    rst = 1; step(); step();
    check("rst_imem_address", imem_bus.imem_address, 64'd0);
    check("rst_valid", 64'(ifid_valid), 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    rst = 0;

    // Sequential fetch; the 16-byte instance runs the same program
    for (int k = 0; k < 4; k++) begin
      step();
      check("seq_instr", 64'(ifid_instruction), 64'(prog[k]));
      check("seq_pc", ifid_pc, 64'(k * 4));
      check("seq_valid", 64'(ifid_valid), 64'd1);
    end
    check("seq_count", 64'(fetch_count), 64'd4);
    check("small_last_pc", ipc16, 64'd12);
    check("small_last_instr", 64'(instr16), 64'(prog[3]));
    check("small_no_fault_yet", 64'(fault16), 64'd0);

    // Redirect to 0; small instance runs off its end on this edge
    branch_taken = 1; branch_target = 64'd0; step(); branch_taken = 0;
    check("bubble_valid", 64'(ifid_valid), 64'd0);
    check("small_fault", 64'(fault16), 64'd1);
    check("small_fault_pc", fpc16, 64'd16);
    check("small_count", 64'(cnt16), 64'd4);
    check("small_valid", 64'(valid16), 64'd0);
    step();
    check("target_word", 64'(ifid_instruction), 64'(prog[0]));
    step();

    // Stall for three cycles while IF/ID holds pc 4
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_pc", ifid_pc, 64'd4);
      check("stall_instr", 64'(ifid_instruction), 64'(prog[1]));
      check("stall_addr", imem_bus.imem_address, 64'd8);
    end
    stall = 0; step();
    check("resume_pc", ifid_pc, 64'd8);

    // Branch with simultaneous stall at pc 12
    branch_taken = 1; branch_target = 64'd0; stall = 1; step();
    branch_taken = 0; stall = 0;
    check("brstall_valid", 64'(ifid_valid), 64'd0);
    check("brstall_addr", imem_bus.imem_address, 64'd0);
    step();
    check("brstall_instr", 64'(ifid_instruction), 64'(prog[0]));

    // Misaligned branch target, then FAULT ignores all stimulus
    branch_taken = 1; branch_target = 64'd6; step();
    check("mis_fault", 64'(fault), 64'd1);
    check("mis_fault_pc", fault_pc, 64'd6);
    for (int k = 0; k < 10; k++) begin
      stall = 1'($urandom); branch_taken = 1'($urandom);
      branch_target = 64'($urandom_range(0, 63) * 4);
      step();
      check("fault_sticky", 64'(fault), 64'd1);
    end
    stall = 0; branch_taken = 0;
    rst = 1; step(); rst = 0;
    check("fault_cleared_addr", imem_bus.imem_address, 64'd0);

    // Reset mid-stream with a branch request
    step(); step();
    check("mid_addr", imem_bus.imem_address, 64'd8);
    rst = 1; branch_taken = 1; branch_target = 64'd40; step();
    rst = 0; branch_taken = 0;
    check("mid_rst_valid", 64'(ifid_valid), 64'd0);
    check("mid_rst_addr", imem_bus.imem_address, 64'd0);

    // Last word of memory fetched, next pc faults
    branch_taken = 1; branch_target = 64'(MSZ - 4); step(); branch_taken = 0;
    step();
    check("edge_pc", ifid_pc, 64'(MSZ - 4));
    step();
    check("edge_fault_pc", fault_pc, 64'(MSZ));
    rst = 1; step(); rst = 0;

    // Out-of-range target that a 32-bit compare would see as zero
    branch_taken = 1; branch_target = 64'h1_0000_0000; step(); branch_taken = 0;
    check("wide_fault_pc", fault_pc, 64'h1_0000_0000);
    rst = 1; step(); rst = 0;

    // Randomized phase
    for (int k = 0; k < 400; k++) begin
      int r;
      rst = ($urandom % 20) == 0;
      stall = ($urandom % 4) == 0;
      branch_taken = ($urandom % 7) == 0;
      r = int'($urandom % 10);
      if (r < 8)       branch_target = 64'($urandom_range(0, 63) * 4);
      else if (r == 8) branch_target = 64'($urandom_range(0, 300));
      else             branch_target = {$urandom, $urandom};
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the single-issue ARM (LEGv8-style, 64-bit) pipeline: owns the program counter, drives the byte address into the instruction memory, and captures the returned 32-bit little-endian word into the IF/ID pipeline register. It sits directly upstream of the instruction memory and directly upstream of decode. It supports stall, branch redirect with flush, and a sticky fetch-fault state for misaligned or out-of-range PCs.

## Interface

Parameters:
- ADDR_WIDTH, 64, PC and memory address width
- INSTR_WIDTH, 32, instruction word width
- IMEM_SIZE, 256, instruction memory size in bytes; must match the memory instance
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold PC and IF/ID contents (hazard unit)
- branch_taken  input  1  redirect request from execute
- branch_target  input  ADDR_WIDTH  redirect address, valid while branch_taken=1
- imem_address  output  ADDR_WIDTH  combinational copy of PC, to instruction memory
- imem_data  input  INSTR_WIDTH  combinational word returned by instruction memory
- ifid_pc  output  ADDR_WIDTH  PC of the captured instruction
- ifid_instruction  output  INSTR_WIDTH  captured instruction word
- ifid_valid  output  1  IF/ID holds a real instruction
- fault  output  1  sticky fetch fault
- fault_pc  output  ADDR_WIDTH  offending address that caused the fault
- fetch_count  output  32  number of instructions delivered into IF/ID

## Operation

- State machine: RUN, FAULT. Reset -> RUN. RUN -> FAULT on a bad address (below). FAULT is left only by rst.
- Bad address: low two bits non-zero, or value > IMEM_SIZE-4.
- RUN, priority per edge (highest first):
  1. branch_taken=1: branch_target is bad -> FAULT, fault_pc<=branch_target, ifid_valid<=0. Otherwise pc<=branch_target, ifid_valid<=0, ifid_instruction<=0 (flush). branch_taken overrides stall.
  2. stall=1: pc, ifid_*, fetch_count hold.
  3. Otherwise: if pc is bad -> FAULT, fault_pc<=pc, ifid_valid<=0. Else ifid_pc<=pc, ifid_instruction<=imem_data, ifid_valid<=1, pc<=pc+4, fetch_count+=1.
- FAULT: pc holds, ifid_valid=0, fault=1, all inputs ignored.
- pc+4 arithmetic is ADDR_WIDTH-bit modulo. Range checks use full-width comparison, never truncated.
- fetch_count wraps modulo 2^32.

## Timing

- Reset values: pc=RESET_PC (so imem_address=RESET_PC), ifid_pc=0, ifid_instruction=0, ifid_valid=0, fault=0, fault_pc=0, fetch_count=0, state=RUN.
- imem_address follows pc with zero latency. The memory is combinational, so the word for pc is captured on the same edge that advances pc.
- Fetch latency: 1 cycle from pc to ifid_* valid.
- Steady state: 1 instruction/cycle.
- Redirect penalty: 1 bubble. On the edge with branch_taken=1, IF/ID is flushed. The target's word appears in IF/ID one edge later.
- rst asserted mid-operation (including in FAULT) restores all reset values on that edge, regardless of stall or branch_taken.
- A PC at IMEM_SIZE-4 is fetched normally. The following pc=IMEM_SIZE faults on the next non-stalled edge.

## Structure

- Shared package `arm_pkg`:
  - ADDR_WIDTH and INSTR_WIDTH defaults
  - state typedef {RUN, FAULT}
  - NOP/flush constant (32'h0)
  - INSTR_BYTES=4
- One natural sub-module: `ifid_register`, holding ifid_pc, ifid_instruction and ifid_valid, with load/flush/hold controls.
- PC, FSM, fault capture and counter live in the top module.

## Test plan

- Sequential fetch, memory preloaded with 0x8b1f03e5, 0xf84000a4, 0x8b040086, 0xf80010a6 at 0/4/8/12. Release rst, run 4 cycles -> ifid_instruction in that order, ifid_pc 0,4,8,12, fetch_count=4, ifid_valid=1 from the first edge after reset.
- Stall: assert stall for 3 cycles while ifid_pc=4 -> ifid_pc=4, ifid_instruction=0xf84000a4 and imem_address=8 held. Resumes with 8 on release.
- Branch with simultaneous stall: branch_taken=1, branch_target=0, stall=1 at pc=12 -> next cycle ifid_valid=0, imem_address=0. Following cycle ifid_instruction=0x8b1f03e5.
- Misaligned branch: branch_target=6 -> fault=1, fault_pc=6, ifid_valid=0. Stays in FAULT for 10 cycles despite stimulus; rst clears it, imem_address=0.
- Run off end, IMEM_SIZE=16: after fetching pc=12, next edge -> fault=1, fault_pc=16, fetch_count=4.
- Reset mid-stream: rst at pc=8 with branch_taken=1 -> all outputs at reset values next cycle.
